// File: rtl/rv6_bus_pkg.sv
// Shared bus definitions for the line responder: widths, FSM states, request source.
package rv6_bus_pkg;
  localparam int ADDR_W = 64;
  localparam int LINE_W = 1024;
  localparam int WORD_W = 64;
  localparam int BEATS  = LINE_W / WORD_W;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int OFF_W  = $clog2(LINE_W / 8);   // byte offset inside a line
  localparam int BYTE_W = $clog2(WORD_W / 8);   // byte offset inside a word
  localparam int TAG_W  = ADDR_W - OFF_W;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;
  typedef enum logic {SRC_I = 1'b0, SRC_D = 1'b1} src_e;
endpackage

// File: rtl/mem_resp_arb.sv
// Two-way round-robin arbiter between instruction and data requesters.
module mem_resp_arb
  import rv6_bus_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic req_d,
  input  logic grant_en,
  output logic gnt_i,
  output logic gnt_d
);
  src_e last_grant_q, last_grant_d;

  // On a tie the side that was not granted last wins; lone requesters win at once.
  always_comb begin
    gnt_i        = 1'b0;
    gnt_d        = 1'b0;
    last_grant_d = last_grant_q;
    if (grant_en) begin
      if (req_d && (!req_i || last_grant_q == SRC_I)) gnt_d = 1'b1;
      else if (req_i)                                 gnt_i = 1'b1;
      if (gnt_d)      last_grant_d = SRC_D;
      else if (gnt_i) last_grant_d = SRC_I;
    end
  end

  // Remember who won; reset says instruction went last so data wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= SRC_I;
    else     last_grant_q <= last_grant_d;
  end
endmodule

// File: rtl/mem_resp.sv
// Line responder: serves hart line reads/writes as 16-beat word bursts.
// Optional one-entry line buffer enabled by defining MEM_RESP_LBUF_EN.
module mem_resp
  import rv6_bus_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic              b_rd_i,
  output logic [LINE_W-1:0] b_data_i,
  output logic              b_dv_i,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_rd,
  input  logic              b_wr,
  input  logic [LINE_W-1:0] b_data_out,
  output logic [LINE_W-1:0] b_data_in,
  output logic              b_dv,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_rd,
  output logic              m_wr,
  output logic [WORD_W-1:0] m_wdata,
  input  logic [WORD_W-1:0] m_rdata,
  input  logic              m_ack
);
  state_e            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [TAG_W-1:0]  line_q, line_d;
  src_e              src_q, src_d;
  logic [LINE_W-1:0] buf_q, buf_d;
  logic              m_rd_q, m_rd_d, m_wr_q, m_wr_d;
  logic              dvi_q, dvi_d, dvd_q, dvd_d;

  logic              gnt_i, gnt_d;
  src_e              req_src;
  logic [TAG_W-1:0]  req_line;
  logic              req_wr, hit, last_beat, burst_done;
  logic              unused_ok;

  mem_resp_arb u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    (b_rd_i),
    .req_d    (b_rd | b_wr),
    .grant_en (state_q == IDLE),
    .gnt_i    (gnt_i),
    .gnt_d    (gnt_d)
  );

  assign req_src    = gnt_d ? SRC_D : SRC_I;
  assign req_line   = gnt_d ? b_addr[ADDR_W-1:OFF_W] : b_addr_i[ADDR_W-1:OFF_W];
  assign req_wr     = gnt_d & b_wr;   // write beats a simultaneous read
  assign last_beat  = (beat_q == BEAT_W'(BEATS - 1));
  assign burst_done = (state_q == RD || state_q == WR) && m_ack && last_beat;
  assign unused_ok  = ^{b_addr[OFF_W-1:0], b_addr_i[OFF_W-1:0]};

`ifdef MEM_RESP_LBUF_EN
  // The line register doubles as buffer storage; only tag and valid are extra.
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             tag_vld_q, tag_vld_d;

  assign hit = tag_vld_q && (tag_q == req_line) && !req_wr;

  // Invalidate when a burst starts overwriting the line register, revalidate on completion.
  always_comb begin
    tag_d     = tag_q;
    tag_vld_d = tag_vld_q;
    if (state_q == IDLE && (gnt_i || gnt_d) && !hit) tag_vld_d = 1'b0;
    if (burst_done) begin
      tag_d     = line_q;
      tag_vld_d = 1'b1;
    end
  end

  // Buffer tag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q     <= '0;
      tag_vld_q <= 1'b0;
    end else begin
      tag_q     <= tag_d;
      tag_vld_q <= tag_vld_d;
    end
  end
`else
  assign hit = 1'b0;
`endif

  // Next-state: grant/latch in IDLE, one word per ack in RD/WR, single dv pulse into DONE.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    line_d  = line_q;
    src_d   = src_q;
    buf_d   = buf_q;
    m_rd_d  = m_rd_q;
    m_wr_d  = m_wr_q;
    dvi_d   = 1'b0;
    dvd_d   = 1'b0;
    case (state_q)
      IDLE: if (gnt_i || gnt_d) begin
        src_d  = req_src;
        line_d = req_line;
        beat_d = '0;
        if (hit) begin
          state_d = DONE;
          dvi_d   = (req_src == SRC_I);
          dvd_d   = (req_src == SRC_D);
        end else if (req_wr) begin
          state_d = WR;
          m_wr_d  = 1'b1;
          buf_d   = b_data_out;
        end else begin
          state_d = RD;
          m_rd_d  = 1'b1;
        end
      end
      RD, WR: if (m_ack) begin
        if (state_q == RD) buf_d[int'(beat_q) * WORD_W +: WORD_W] = m_rdata;
        beat_d = beat_q + 1'b1;   // wraps to 0 on the last beat
        if (last_beat) begin
          state_d = DONE;
          m_rd_d  = 1'b0;
          m_wr_d  = 1'b0;
          dvi_d   = (src_q == SRC_I);
          dvd_d   = (src_q == SRC_D);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset drops strobes and discards any partial line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      line_q  <= '0;
      src_q   <= SRC_I;
      buf_q   <= '0;
      m_rd_q  <= 1'b0;
      m_wr_q  <= 1'b0;
      dvi_q   <= 1'b0;
      dvd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      src_q   <= src_d;
      buf_q   <= buf_d;
      m_rd_q  <= m_rd_d;
      m_wr_q  <= m_wr_d;
      dvi_q   <= dvi_d;
      dvd_q   <= dvd_d;
    end
  end

  assign b_data_i  = buf_q;
  assign b_data_in = buf_q;
  assign b_dv_i    = dvi_q;
  assign b_dv      = dvd_q;
  assign m_rd      = m_rd_q;
  assign m_wr      = m_wr_q;
  assign m_addr    = {line_q, beat_q, {BYTE_W{1'b0}}};
  assign m_wdata   = buf_q[int'(beat_q) * WORD_W +: WORD_W];
endmodule

// File: tb/tb_mem_resp.sv
// Scoreboard bench for mem_resp: stimulus queues expected dv events and bus beats,
// monitors pop and compare. Adapts expected timing when MEM_RESP_LBUF_EN is defined.
module tb_mem_resp;
  import rv6_bus_pkg::*;
`ifdef MEM_RESP_LBUF_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  logic              clk = 1'b0, rst;
  logic [ADDR_W-1:0] b_addr_i, b_addr, m_addr;
  logic              b_rd_i, b_rd, b_wr, b_dv_i, b_dv, m_rd, m_wr, m_ack;
  logic [LINE_W-1:0] b_data_i, b_data_in, b_data_out;
  logic [WORD_W-1:0] m_wdata, m_rdata;

  mem_resp dut (
    .clk(clk), .rst(rst),
    .b_addr_i(b_addr_i), .b_rd_i(b_rd_i), .b_data_i(b_data_i), .b_dv_i(b_dv_i),
    .b_addr(b_addr), .b_rd(b_rd), .b_wr(b_wr), .b_data_out(b_data_out),
    .b_data_in(b_data_in), .b_dv(b_dv),
    .m_addr(m_addr), .m_rd(m_rd), .m_wr(m_wr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;

  typedef struct {bit src_d; logic [LINE_W-1:0] line; int cyc; bit chk;} dv_t;
  typedef struct {bit wr; logic [63:0] addr; logic [63:0] wdata;} beat_t;
  dv_t   sb_q[$];
  beat_t bt_q[$];

  logic [63:0] mem [logic [63:0]];
  int          stall_left = 0;
  logic [63:0] stall_addr = '1;
  int          hold_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_line(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      for (int n = 0; n < BEATS; n++)
        if (act[64*n +: 64] !== exp[64*n +: 64]) begin
          $display("FAIL %s: word %0d got %h want %h (cycle %0d)", nm, n, act[64*n +: 64], exp[64*n +: 64], cyc);
          break;
        end
    end
  endtask

  function automatic logic [LINE_W-1:0] line_inc(input logic [63:0] base, input logic [63:0] step);
    logic [LINE_W-1:0] l;
    for (int n = 0; n < BEATS; n++) l[64*n +: 64] = base + step * 64'(n);
    return l;
  endfunction

  // Memory model: unwritten words read back as their own address.
  initial begin
    m_ack = 1'b0; m_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (m_rd || m_wr) begin
        if (stall_left > 0 && m_addr == stall_addr) begin
          m_ack = 1'b0; stall_left--;
        end else begin
          m_ack = 1'b1;
          m_rdata = mem.exists(m_addr) ? mem[m_addr] : m_addr;
        end
      end else m_ack = 1'b0;
    end
  end

  // Monitor: dv events against scoreboard, acked beats against expected beat queue.
  initial begin
    dv_t e; beat_t b;
    forever begin
      @(negedge clk);
      if (b_dv || b_dv_i) begin
        chk("dv_exclusive", {63'd0, b_dv & b_dv_i}, 64'd0);
        if (sb_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_dv: b_dv=%0b b_dv_i=%0b at cycle %0d, want no dv", b_dv, b_dv_i, cyc);
        end else begin
          e = sb_q.pop_front();
          chk("dv_src", {63'd0, b_dv}, {63'd0, e.src_d});
          chk("dv_cycle", cyc, e.cyc);
          if (e.chk) chk_line("dv_line", e.src_d ? b_data_in : b_data_i, e.line);
        end
      end
      if ((m_rd || m_wr) && m_ack) begin
        if (bt_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_beat: m_addr=%h m_wr=%0b at cycle %0d, want no beat", m_addr, m_wr, cyc);
        end else begin
          b = bt_q.pop_front();
          chk("beat_wr", {63'd0, m_wr}, {63'd0, b.wr});
          chk("beat_addr", m_addr, b.addr);
          if (b.wr) chk("beat_wdata", m_wdata, b.wdata);
        end
        if (m_wr) mem[m_addr] = m_wdata;
      end
      if (m_rd && m_addr == stall_addr) hold_cnt++;
    end
  end

  task automatic wait_dv(output bit got_d);
    bit ok = 1'b0;
    got_d = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (b_dv || b_dv_i) begin ok = 1'b1; got_d = b_dv; break; end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL dv_timeout: no dv within 200 cycles, want one");
    end
  endtask

  task automatic check_zero(input string tag);
    chk_line({tag, "_b_data_i"}, b_data_i, '0);
    chk_line({tag, "_b_data_in"}, b_data_in, '0);
    chk({tag, "_dv"}, {62'd0, b_dv, b_dv_i}, 64'd0);
    chk({tag, "_m_strobe"}, {62'd0, m_rd, m_wr}, 64'd0);
    chk({tag, "_m_addr"}, m_addr, 64'd0);
    chk({tag, "_m_wdata"}, m_wdata, 64'd0);
  endtask

  // One request, held until its dv; hit_lb marks an expected line-buffer hit.
  task automatic do_req(input bit src_d, input bit wr, input logic [63:0] addr,
                        input logic [LINE_W-1:0] wline, input logic [LINE_W-1:0] exp_line,
                        input int extra, input bit hit_lb);
    bit hit, gd;
    int t;
    hit = LB && hit_lb;
    @(posedge clk); #1;
    t = cyc;
    if (src_d) begin b_addr = addr; b_data_out = wline; b_wr = wr; b_rd = !wr; end
    else begin b_addr_i = addr; b_rd_i = 1'b1; end
    if (!hit)
      for (int n = 0; n < BEATS; n++) bt_q.push_back('{wr, addr + 64'(8 * n), wline[64*n +: 64]});
    sb_q.push_back('{src_d, exp_line, t + (hit ? 1 : 17 + extra), !wr});
    wait_dv(gd);
    b_rd = 1'b0; b_wr = 1'b0; b_rd_i = 1'b0;
  endtask

  logic [LINE_W-1:0] pat1, pat2;

  initial begin
    int t;
    bit gd;
    rst = 1'b1; b_addr_i = '0; b_rd_i = 1'b0; b_addr = '0; b_rd = 1'b0; b_wr = 1'b0; b_data_out = '0;
    pat1 = line_inc(64'hA5A5_0000, 64'd1);
    pat2 = line_inc(64'hC0DE_0000, 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // Both requesters held and re-raised after each dv: D, I, D, I.
    @(posedge clk); #1;
    t = cyc;
    b_addr = 64'h3000; b_addr_i = 64'h4000; b_rd = 1'b1; b_rd_i = 1'b1;
    for (int g = 0; g < 4; g++) begin
      logic [63:0] base;
      base = (g % 2 == 0) ? 64'h3000 : 64'h4000;
      for (int n = 0; n < BEATS; n++) bt_q.push_back('{1'b0, base + 64'(8 * n), 64'd0});
      sb_q.push_back('{(g % 2 == 0), line_inc(base, 64'd8), t + 17 + 18 * g, 1'b1});
    end
    for (int g = 0; g < 4; g++) begin
      wait_dv(gd);
      if (gd) b_rd = 1'b0; else b_rd_i = 1'b0;
      if (g < 3) begin @(posedge clk); #1; b_rd = 1'b1; b_rd_i = 1'b1; end
    end
    b_rd = 1'b0; b_rd_i = 1'b0;

    // Instruction read, zero-wait.
    do_req(1'b0, 1'b0, 64'h1000_0080, '0, line_inc(64'h1000_0080, 64'd8), 0, 1'b0);
    // Data write then read back of the same line.
    do_req(1'b1, 1'b1, 64'h2000, pat1, '0, 0, 1'b0);
    do_req(1'b1, 1'b0, 64'h2000, '0, pat1, 0, 1'b1);

    // Three wait cycles on beat 7.
    stall_addr = 64'h6038; stall_left = 3; hold_cnt = 0;
    do_req(1'b0, 1'b0, 64'h6000, '0, line_inc(64'h6000, 64'd8), 3, 1'b0);
    chk("stall_hold_cycles", 64'(hold_cnt), 64'd4);

    // Reset at beat 9 of a read.
    @(posedge clk); #1;
    t = cyc;
    b_addr_i = 64'h5000; b_rd_i = 1'b1;
    for (int n = 0; n < BEATS; n++) bt_q.push_back('{1'b0, 64'h5000 + 64'(8 * n), 64'd0});
    repeat (10) @(posedge clk);
    #1;
    chk("rst_beat9_addr", m_addr, 64'h5048);
    rst = 1'b1; b_rd_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    bt_q.delete();
    repeat (20) @(posedge clk);
    do_req(1'b0, 1'b0, 64'h5000, '0, line_inc(64'h5000, 64'd8), 0, 1'b0);

    // Repeat read (buffer hit when enabled), write, then re-read sees new data.
    do_req(1'b0, 1'b0, 64'h5000, '0, line_inc(64'h5000, 64'd8), 0, 1'b1);
    do_req(1'b1, 1'b1, 64'h5000, pat2, '0, 0, 1'b0);
    do_req(1'b0, 1'b0, 64'h5000, '0, pat2, 0, 1'b1);

    repeat (5) @(posedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    chk("beats_drained", 64'(bt_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
